// File: rtl/ibex_instr_mem_responder.sv
// Word-addressed instruction memory serving the req/gnt/rvalid fetch bus with a
// bounded in-order response queue, fixed response latency and a preload port.
module ibex_instr_mem_responder #(
  parameter int unsigned Depth          = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned RespLatency    = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     instr_req_i,
  input  logic [31:0]              instr_addr_i,
  output logic                     instr_gnt_o,
  output logic                     instr_rvalid_o,
  output logic [31:0]              instr_rdata_o,
  output logic                     instr_err_o,
  input  logic                     stall_i,
  input  logic                     load_we_i,
  input  logic [$clog2(Depth)-1:0] load_addr_i,
  input  logic [31:0]              load_wdata_i,
  output logic                     busy_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam int unsigned LW = (RespLatency > 1) ? $clog2(RespLatency) : 1;

  localparam logic [32:0]   Span     = 33'(Depth) << 2;
  localparam logic [LW-1:0] LatInit  = LW'(RespLatency - 1);
  localparam logic [CW-1:0] MaxCnt   = CW'(MaxOutstanding);
  localparam logic [PW-1:0] LastPtr  = PW'(MaxOutstanding - 1);

  logic [31:0]   mem     [Depth];
  logic [31:0]   q_rdata [MaxOutstanding];
  logic          q_err   [MaxOutstanding];
  logic [LW-1:0] q_cnt   [MaxOutstanding];
  logic [MaxOutstanding-1:0] q_valid;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] out_cnt;

  logic [31:0]   addr_off;
  logic          addr_hit;
  logic [AW-1:0] word_idx;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Offset compared in 33 bits so Depth*4 cannot wrap for large memories.
  assign addr_off = instr_addr_i - BaseAddr;
  assign addr_hit = (instr_addr_i >= BaseAddr) && ({1'b0, addr_off} < Span);
  assign word_idx = addr_off[AW+1:2];

  // Uses the registered count, so a pop this cycle frees a slot only next cycle.
  assign instr_gnt_o = instr_req_i & ~stall_i & (out_cnt < MaxCnt);

  assign push = instr_gnt_o;
  assign pop  = q_valid[rd_ptr] && (q_cnt[rd_ptr] == '0);

  assign instr_rvalid_o = pop;
  assign instr_rdata_o  = pop ? q_rdata[rd_ptr] : 32'h0;
  assign instr_err_o    = pop ? q_err[rd_ptr]   : 1'b0;
  assign busy_o         = (out_cnt != '0);

  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem[load_addr_i] <= load_wdata_i;
    end
  end

  // Payload needs no reset: every use is qualified by q_valid.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < MaxOutstanding; i++) begin
      if (q_valid[i] && (q_cnt[i] != '0)) begin
        q_cnt[i] <= q_cnt[i] - 1'b1;
      end
    end
    if (push) begin
      q_rdata[wr_ptr] <= addr_hit ? mem[word_idx] : 32'h0;
      q_err[wr_ptr]   <= ~addr_hit;
      q_cnt[wr_ptr]   <= LatInit;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_valid <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      out_cnt <= '0;
    end else begin
      // The write slot is always free when granting, so push and pop never collide.
      if (push) begin
        q_valid[wr_ptr] <= 1'b1;
        wr_ptr          <= ptr_next(wr_ptr);
      end
      if (pop) begin
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Directed bench: three responder instances (latency 1, 4 and 3) sharing clock,
// reset, stall and preload bus, each with its own fetch port.
module tb_ibex_instr_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [31:0] load_wdata;

  logic        req_a, gnt_a, rvalid_a, err_a, busy_a;
  logic [31:0] addr_a, rdata_a;
  logic        req_b, gnt_b, rvalid_b, err_b, busy_b;
  logic [31:0] addr_b, rdata_b;
  logic        req_c, gnt_c, rvalid_c, err_c, busy_c;
  logic [31:0] addr_c, rdata_c;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ibex_instr_mem_responder #(.Depth(1024), .BaseAddr(32'h0), .MaxOutstanding(2), .RespLatency(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req_a), .instr_addr_i(addr_a), .instr_gnt_o(gnt_a),
    .instr_rvalid_o(rvalid_a), .instr_rdata_o(rdata_a), .instr_err_o(err_a), .stall_i(stall),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata), .busy_o(busy_a));

  ibex_instr_mem_responder #(.Depth(1024), .BaseAddr(32'h0), .MaxOutstanding(2), .RespLatency(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req_b), .instr_addr_i(addr_b), .instr_gnt_o(gnt_b),
    .instr_rvalid_o(rvalid_b), .instr_rdata_o(rdata_b), .instr_err_o(err_b), .stall_i(stall),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata), .busy_o(busy_b));

  ibex_instr_mem_responder #(.Depth(1024), .BaseAddr(32'h0), .MaxOutstanding(2), .RespLatency(3)) dut_c (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req_c), .instr_addr_i(addr_c), .instr_gnt_o(gnt_c),
    .instr_rvalid_o(rvalid_c), .instr_rdata_o(rdata_c), .instr_err_o(err_c), .stall_i(stall),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata), .busy_o(busy_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; load_we = 1'b0; load_addr = '0; load_wdata = '0;
    req_a = 1'b1; addr_a = 32'h0;
    req_b = 1'b0; addr_b = 32'h0;
    req_c = 1'b0; addr_c = 32'h0;

    // Reset state; grant still follows req & ~stall
    #2;
    check("rst_rvalid", 32'(rvalid_a), 32'd0);
    check("rst_rdata",  rdata_a,       32'h0);
    check("rst_err",    32'(err_a),    32'd0);
    check("rst_busy",   32'(busy_a),   32'd0);
    check("rst_gnt",    32'(gnt_a),    32'd1);
    stall = 1'b1; settle();
    check("rst_gnt_stall", 32'(gnt_a), 32'd0);
    stall = 1'b0; req_a = 1'b0;

    step(); rst = 1'b0;

    // Preload words 0..3, 5 and 1023
    for (int k = 0; k < 4; k++) begin
      step(); load_we = 1'b1; load_addr = 10'(k); load_wdata = 32'h1111_1111 * 32'(k);
    end
    step(); load_addr = 10'd5;    load_wdata = 32'h0;
    step(); load_addr = 10'd1023; load_wdata = 32'hCAFE_F00D;
    step(); load_we = 1'b0;

    // Back-to-back fetches, latency 1
    for (int i = 0; i < 4; i++) begin
      step(); req_a = 1'b1; addr_a = 32'(4 * i); settle();
      check($sformatf("fetch_gnt%0d", i), 32'(gnt_a), 32'd1);
      if (i > 0) begin
        check($sformatf("fetch_rv%0d", i - 1), 32'(rvalid_a), 32'd1);
        check($sformatf("fetch_rd%0d", i - 1), rdata_a, 32'h1111_1111 * 32'(i - 1));
        check($sformatf("fetch_err%0d", i - 1), 32'(err_a), 32'd0);
      end
    end
    step(); req_a = 1'b0; settle();
    check("fetch_rv3", 32'(rvalid_a), 32'd1);
    check("fetch_rd3", rdata_a, 32'h3333_3333);
    step(); settle();
    check("fetch_idle_rv",   32'(rvalid_a), 32'd0);
    check("fetch_idle_rd",   rdata_a,       32'h0);
    check("fetch_idle_busy", 32'(busy_a),   32'd0);

    // Out-of-range and last in-range word
    step(); req_a = 1'b1; addr_a = 32'h1000; settle();
    check("oor_gnt", 32'(gnt_a), 32'd1);
    step(); addr_a = 32'h0FFC; settle();
    check("last_gnt", 32'(gnt_a), 32'd1);
    check("oor_rv",   32'(rvalid_a), 32'd1);
    check("oor_err",  32'(err_a),    32'd1);
    check("oor_rd",   rdata_a,       32'h0);
    step(); req_a = 1'b0; settle();
    check("last_rv",  32'(rvalid_a), 32'd1);
    check("last_err", 32'(err_a),    32'd0);
    check("last_rd",  rdata_a,       32'hCAFE_F00D);

    // Stall blocks grants for three cycles
    for (int i = 0; i < 3; i++) begin
      step(); stall = 1'b1; req_a = 1'b1; addr_a = 32'h4; settle();
      check($sformatf("stall_gnt%0d", i), 32'(gnt_a),    32'd0);
      check($sformatf("stall_rv%0d", i),  32'(rvalid_a), 32'd0);
    end
    step(); stall = 1'b0; settle();
    check("unstall_gnt", 32'(gnt_a), 32'd1);
    step(); req_a = 1'b0; settle();
    check("unstall_rv", 32'(rvalid_a), 32'd1);
    check("unstall_rd", rdata_a,       32'h1111_1111);

    // Load/read collision on word 5
    step(); load_we = 1'b1; load_addr = 10'd5; load_wdata = 32'hDEAD_BEEF;
    req_a = 1'b1; addr_a = 32'h14; settle();
    check("coll_gnt0", 32'(gnt_a), 32'd1);
    step(); load_we = 1'b0; settle();
    check("coll_gnt1", 32'(gnt_a), 32'd1);
    check("coll_old",  rdata_a, 32'h0);
    step(); req_a = 1'b0; settle();
    check("coll_new",  rdata_a, 32'hDEAD_BEEF);
    step();

    // Outstanding limit: latency 4, two slots
    step(); req_b = 1'b1; addr_b = 32'h0; settle();
    check("lim_gnt_t0",  32'(gnt_b),  32'd1);
    check("lim_busy_t0", 32'(busy_b), 32'd0);
    step(); addr_b = 32'h4; settle();
    check("lim_gnt_t1",  32'(gnt_b),  32'd1);
    check("lim_busy_t1", 32'(busy_b), 32'd1);
    step(); addr_b = 32'h8; settle();
    check("lim_gnt_t2", 32'(gnt_b), 32'd0);
    check("lim_rv_t2",  32'(rvalid_b), 32'd0);
    step(); settle();
    check("lim_gnt_t3", 32'(gnt_b), 32'd0);
    check("lim_rv_t3",  32'(rvalid_b), 32'd0);
    step(); settle();
    check("lim_gnt_t4", 32'(gnt_b), 32'd0);
    check("lim_rv_t4",  32'(rvalid_b), 32'd1);
    check("lim_rd_t4",  rdata_b, 32'h0);
    step(); settle();
    check("lim_gnt_t5", 32'(gnt_b), 32'd1);
    check("lim_rv_t5",  32'(rvalid_b), 32'd1);
    check("lim_rd_t5",  rdata_b, 32'h1111_1111);
    step(); req_b = 1'b0; settle();
    check("lim_rv_t6", 32'(rvalid_b), 32'd0);
    step(); step(); settle();
    check("lim_rv_t8", 32'(rvalid_b), 32'd0);
    step(); settle();
    check("lim_rv_t9", 32'(rvalid_b), 32'd1);
    check("lim_rd_t9", rdata_b, 32'h2222_2222);
    step(); settle();
    check("lim_busy_end", 32'(busy_b), 32'd0);

    // Reset mid-flight: latency 3
    step(); req_c = 1'b1; addr_c = 32'h0; settle();
    check("rmf_gnt0", 32'(gnt_c), 32'd1);
    step(); addr_c = 32'h4; settle();
    check("rmf_gnt1", 32'(gnt_c), 32'd1);
    step(); req_c = 1'b0; settle();
    check("rmf_busy_pre", 32'(busy_c), 32'd1);
    rst = 1'b1; settle();
    check("rmf_busy_rst", 32'(busy_c),   32'd0);
    check("rmf_rv_rst",   32'(rvalid_c), 32'd0);
    step(); rst = 1'b0; settle();
    check("rmf_rv_t3", 32'(rvalid_c), 32'd0);
    step(); req_c = 1'b1; addr_c = 32'h8; settle();
    check("rmf_gnt_new", 32'(gnt_c),    32'd1);
    check("rmf_rv_t4",   32'(rvalid_c), 32'd0);
    step(); req_c = 1'b0; settle();
    check("rmf_rv_t5", 32'(rvalid_c), 32'd0);
    step(); settle();
    check("rmf_rv_t6", 32'(rvalid_c), 32'd0);
    step(); settle();
    check("rmf_rv_new", 32'(rvalid_c), 32'd1);
    check("rmf_rd_new", rdata_c, 32'h2222_2222);
    step(); settle();
    check("rmf_busy_end", 32'(busy_c), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ibex_instr_mem_responder.md
# ibex_instr_mem_responder

Word-addressed instruction memory that acts as the responder on the core's instruction fetch bus (req/gnt/rvalid). It is the slave the prefetch buffer talks to in simulation and small FPGA builds. It grants requests, supports a bounded number of pipelined outstanding transactions, and returns data in order after a fixed latency. Out-of-range accesses return a bus error. A separate load port preloads program contents.

## Interface

Parameters:
- Depth, 1024: number of 32-bit words; must be a power of two, ≥2.
- BaseAddr, 32'h0000_0000: byte address of word 0; aligned to Depth*4.
- MaxOutstanding, 2: maximum granted-but-unanswered requests; range 1..4.
- RespLatency, 1: cycles from the grant cycle to the rvalid cycle; range 1..8.

Ports:
- Clocking and reset:
  - clk_i  in  1  clock; all state on rising edge.
  - rst_i  in  1  reset; asynchronous, active-high.
- Fetch bus:
  - instr_req_i  in  1  fetch request.
  - instr_addr_i  in  32  byte address; bits [1:0] ignored.
  - instr_gnt_o  out  1  grant; combinational.
  - instr_rvalid_o  out  1  response valid; registered state only.
  - instr_rdata_o  out  32  response data.
  - instr_err_o  out  1  response error.
- Control and status:
  - stall_i  in  1  forces instr_gnt_o low; for bus back-pressure testing.
  - load_we_i  in  1  write strobe for preload.
  - load_addr_i  in  $clog2(Depth)  word index for preload.
  - load_wdata_i  in  32  preload data.
  - busy_o  out  1  high while any response is outstanding.

## Operation

- **Grant:** instr_gnt_o = instr_req_i & ~stall_i & (outstanding_cnt < MaxOutstanding). A response popping in the same cycle does not free a slot for that cycle's grant.
- **Range check:** performed at grant.
  - Hit condition: BaseAddr ≤ addr < BaseAddr + Depth*4.
  - On a hit, the word at (addr − BaseAddr) >> 2 is read. Data is sampled in the grant cycle and stored in the response entry.
  - On a miss, the entry stores err=1 and rdata=32'h0.
- **Response queue:** in-order circular queue of MaxOutstanding entries. Each entry holds {rdata, err, cnt}.
  - Push on grant with cnt = RespLatency−1.
  - Each cycle, every valid entry with cnt > 0 decrements.
  - The head is emitted when valid with cnt == 0. instr_rvalid_o, instr_rdata_o and instr_err_o are driven from the head entry's registers, and the head pops the same cycle.
  - At most one response per cycle.
  - Push and pop in the same cycle leave outstanding_cnt unchanged.
  - Read/write pointers wrap modulo MaxOutstanding.
- **rdata/err when idle:** when instr_rvalid_o = 0, instr_rdata_o and instr_err_o are 0.
- **Load port:** a write updates the array at the clock edge.
  - A grant in the same cycle to the same word returns the old data.
  - A grant in the following cycle returns the new data.
- **Other rules:**
  - The responder never drops, reorders or duplicates a granted request.
  - instr_req_i without a grant carries no obligation. The initiator holds its request; the responder keeps no state about it.
  - busy_o = (outstanding_cnt != 0).

## Timing

- **Reset (async, rst_i=1):**
  - Queue is emptied and outstanding_cnt = 0.
  - instr_rvalid_o = 0, instr_rdata_o = 0, instr_err_o = 0, busy_o = 0.
  - instr_gnt_o follows its equation, so it is 1 iff req & ~stall.
  - Memory contents are not reset.
- **Reset mid-operation:** all outstanding responses are discarded; none are emitted after reset deassertion.
- **Latency:** grant in cycle T gives rvalid in cycle T+RespLatency.
- **Throughput:** with MaxOutstanding ≥ RespLatency+1, back-to-back grants are sustained at one per cycle.
- **Full:** when outstanding_cnt == MaxOutstanding, grant is low until the cycle after a pop.
- **stall_i:** only blocks new grants; queued responses still drain on schedule.

## Test plan

- **Preload and fetch:** preload words 0..3 with 32'h1111_1111·k. Hold req with addr 0x0, 0x4, 0x8, 0xC in consecutive cycles (RespLatency=1, MaxOutstanding=2) -> 4 grants in 4 cycles; rvalid in cycles T+1..T+4 with data 0x0, 0x11111111, 0x22222222, 0x33333333; err=0.
- **Out-of-range access:** Depth=1024, BaseAddr=0. Request addr 0x1000 -> granted; rvalid one cycle later with err=1, rdata=0. Request addr 0x0FFC -> err=0.
- **Outstanding limit:** RespLatency=4, MaxOutstanding=2, continuous req -> grants at T and T+1, gnt low at T+2..T+4, rvalids at T+4 and T+5, next grant at T+5; busy_o high from T+1.
- **stall_i:** assert stall_i for 3 cycles while req=1 -> gnt=0 for those cycles, no rvalid generated; grant on the first cycle after stall drops.
- **Load/read collision:** in the same cycle, load word 5 = 0xDEADBEEF (old 0x0) and grant addr 0x14 -> response 0x0. Grant addr 0x14 the next cycle -> 0xDEADBEEF.
- **Reset mid-flight:** RespLatency=3; grant two requests, then assert rst_i one cycle later for one cycle -> no rvalid ever emitted for them; busy_o=0 immediately; first new grant returns correct data after 3 cycles.
